// File: rtl/gpu_cmd_rasterizer.sv
// Graphics command receiver: decodes one GSR command and rasterises it into
// framebuffer word writes, pausing whenever the VGA scan owns the SRAM.
module gpu_cmd_rasterizer #(
    parameter int GSR_W  = 16,
    parameter int VTX_W  = 20,
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 18
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VIDEO_ON,
    input  logic [GSR_W-1:0]  I_GSRValue,
    input  logic              I_GSRValue_Valid,
    input  logic [VTX_W-1:0]  I_VertexV1,
    input  logic [VTX_W-1:0]  I_VertexV2,
    input  logic [VTX_W-1:0]  I_VertexV3,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic [15:0]       O_GPU_DATA,
    output logic              O_GPU_WRITE,
    output logic              O_GPU_READ,
    output logic              O_GPUStallSignal,
    output logic              O_CMD_DROP
);
    localparam int XW = VTX_W / 2;
    localparam logic [XW-1:0] XLIM = XW'(FB_W - 1);
    localparam logic [XW-1:0] YLIM = XW'(FB_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;

    state_t              state_q, state_d;
    logic [11:0]         colour_q, colour_d;
    logic [VTX_W-1:0]    v3_q, v3_d;
    logic [XW-1:0]       xmin_q, xmin_d, xmax_q, xmax_d;
    logic [XW-1:0]       ymin_q, ymin_d, ymax_q, ymax_d;
    logic [XW-1:0]       cx_q, cx_d, cy_q, cy_d;
    logic [ADDR_W-1:0]   rowbase_q, rowbase_d, row_mul;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                write_q, write_d, drop_q, drop_d, tail_q;

    logic [3:0]    opcode;
    logic [XW-1:0] x1, y1, x2, y2;
    logic          unused_v3;

    assign opcode    = I_GSRValue[GSR_W-1:GSR_W-4];
    assign x1        = I_VertexV1[VTX_W-1:XW];
    assign y1        = I_VertexV1[XW-1:0];
    assign x2        = I_VertexV2[VTX_W-1:XW];
    assign y2        = I_VertexV2[XW-1:0];
    assign unused_v3 = ^v3_q;

    // ymin*FB_W as a sum of shifted copies over the set bits of FB_W
    always_comb begin
        row_mul = '0;
        for (int i = 0; i < 32; i++)
            if (FB_W[i] == 1'b1) row_mul = row_mul + (ADDR_W'(ymin_q) << i);
    end

    always_comb begin
        state_d   = state_q;
        colour_d  = colour_q;
        v3_d      = v3_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        rowbase_d = rowbase_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = 1'b0;
        drop_d    = drop_q;
        unique case (state_q)
            IDLE: if (I_GSRValue_Valid) begin
                v3_d = I_VertexV3;
                case (opcode)
                    4'h1: colour_d = I_GSRValue[11:0];
                    4'h2: begin
                        xmin_d = '0;   ymin_d = '0;
                        xmax_d = XLIM; ymax_d = YLIM;
                        state_d = SETUP;
                    end
                    4'h3: begin
                        xmin_d = (x1 < x2) ? x1 : x2;
                        xmax_d = (x1 < x2) ? x2 : x1;
                        ymin_d = (y1 < y2) ? y1 : y2;
                        ymax_d = (y1 < y2) ? y2 : y1;
                        state_d = SETUP;
                    end
                    4'h4: begin
                        xmin_d = x1; xmax_d = x1;
                        ymin_d = y1; ymax_d = y1;
                        state_d = SETUP;
                    end
                    default: ;
                endcase
            end
            SETUP: begin
                if (xmax_q > XLIM) xmax_d = XLIM;
                if (ymax_q > YLIM) ymax_d = YLIM;
                if (xmin_q > XLIM || ymin_q > YLIM) begin
                    state_d = IDLE;
                end else begin
                    rowbase_d = row_mul;
                    cx_d      = xmin_q;
                    cy_d      = ymin_q;
                    state_d   = FILL;
                end
            end
            FILL: if (!I_VIDEO_ON) begin
                write_d = 1'b1;
                addr_d  = rowbase_q + ADDR_W'(cx_q);
                data_d  = {4'b0, colour_q};
                if (cx_q < xmax_q) begin
                    cx_d = cx_q + XW'(1);
                end else begin
                    cx_d      = xmin_q;
                    rowbase_d = rowbase_q + ADDR_W'(FB_W);
                    cy_d      = cy_q + XW'(1);
                    if (cy_q == ymax_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (I_GSRValue_Valid && state_q != IDLE) drop_d = 1'b1;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= IDLE;
            colour_q  <= '0;
            v3_q      <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            rowbase_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            drop_q    <= 1'b0;
            tail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            colour_q  <= colour_d;
            v3_q      <= v3_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            rowbase_q <= rowbase_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            drop_q    <= drop_d;
            tail_q    <= (state_q != IDLE);
        end
    end

    // tail_q keeps the stall up while the final registered write is on the bus
    assign O_GPUStallSignal = (state_q != IDLE) || tail_q;
    assign O_GPU_ADDR       = addr_q;
    assign O_GPU_DATA       = data_q;
    assign O_GPU_WRITE      = write_q;
    assign O_GPU_READ       = 1'b0;
    assign O_CMD_DROP       = drop_q;
endmodule

// File: tb/tb_gpu_cmd_rasterizer.sv
// Directed bench for gpu_cmd_rasterizer: drives commands, captures the write
// stream and stall length per command, and compares against hand-computed values.
module tb_gpu_cmd_rasterizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        video = 1'b0;
    logic [15:0] gsr = '0;
    logic        gsr_vld = 1'b0;
    logic [19:0] v1 = '0, v2 = '0, v3 = '0;
    logic [17:0] addr;
    logic [15:0] data;
    logic        wr, rd, stall, drop;

    int n_cmp = 0;
    int n_err = 0;
    int nstall;
    int wa[$];
    int wd[$];
    logic last_stall;

    gpu_cmd_rasterizer dut (
        .I_CLK(clk), .I_RST(rst), .I_VIDEO_ON(video),
        .I_GSRValue(gsr), .I_GSRValue_Valid(gsr_vld),
        .I_VertexV1(v1), .I_VertexV2(v2), .I_VertexV3(v3),
        .O_GPU_ADDR(addr), .O_GPU_DATA(data), .O_GPU_WRITE(wr),
        .O_GPU_READ(rd), .O_GPUStallSignal(stall), .O_CMD_DROP(drop)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] vtx(input int x, input int y);
        logic [31:0] xx, yy;
        xx = x; yy = y;
        return {xx[9:0], yy[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // one cycle: sample outputs on the falling edge
    task automatic tick();
        @(negedge clk);
        if (wr) begin wa.push_back(int'(addr)); wd.push_back(int'(data)); end
        if (stall) nstall++;
        last_stall = stall;
    endtask

    task automatic strobe(input logic [15:0] g, input logic [19:0] a, input logic [19:0] b);
        gsr = g; v1 = a; v2 = b; v3 = 20'h5A5A5; gsr_vld = 1'b1;
        tick();
        gsr_vld = 1'b0;
    endtask

    task automatic start(input logic [15:0] g, input logic [19:0] a, input logic [19:0] b);
        wa.delete(); wd.delete(); nstall = 0;
        strobe(g, a, b);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (last_stall && n < budget) begin tick(); n++; end
        check({tag, "_done"}, 32'(last_stall), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int exp_a[$], input int exp_d);
        check({tag, "_count"}, 32'(wa.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(exp_a[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(exp_d));
        end
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_write", 32'(wr), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_data", 32'(data), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_read", 32'(rd), 0);

        // SETCOLOR never stalls; POINT (5,2) -> addr 645
        start(16'h1F00, '0, '0);
        drain("setcolor", 10);
        check("setcolor_stall", 32'(nstall), 0);
        check("setcolor_writes", 32'(wa.size()), 0);
        start(16'h4000, vtx(5, 2), '0);
        drain("point", 20);
        check_writes("point", '{645}, 16'h0F00);
        check("point_stall", 32'(nstall), 3);

        // FILLRECT with swapped corners
        start(16'h10F0, '0, '0);
        drain("setcolor2", 10);
        start(16'h3000, vtx(12, 4), vtx(10, 3));
        drain("rect", 40);
        check_writes("rect", '{970, 971, 972, 1290, 1291, 1292}, 16'h00F0);
        check("rect_stall", 32'(nstall), 8);

        // clipping at the bottom-right corner, then a fully off-screen point
        start(16'h3000, vtx(318, 238), vtx(400, 300));
        drain("clip", 40);
        check_writes("clip", '{76478, 76479, 76798, 76799}, 16'h00F0);
        start(16'h4000, vtx(320, 0), '0);
        drain("empty", 20);
        check("empty_writes", 32'(wa.size()), 0);
        check("empty_stall", 32'(nstall), 2);

        // video pause for 3 cycles after the 2nd write
        start(16'h3000, vtx(0, 10), vtx(3, 10));
        bad = 0;
        while (wa.size() < 2 && bad < 20) begin tick(); bad++; end
        check("pause_reach2", 32'(wa.size()), 2);
        video = 1'b1;
        repeat (3) tick();
        check("pause_nowrites", 32'(wa.size()), 2);
        video = 1'b0;
        drain("pause", 40);
        check_writes("pause", '{3200, 3201, 3202, 3203}, 16'h00F0);
        check("pause_stall", 32'(nstall), 9);

        // SETCOLOR during FILL is dropped and flagged
        start(16'h3000, vtx(0, 20), vtx(7, 20));
        bad = 0;
        while (wa.size() < 2 && bad < 20) begin tick(); bad++; end
        strobe(16'h1ABC, '0, '0);
        drain("drop", 40);
        check("drop_flag", 32'(drop), 1);
        check_writes("drop", '{6400, 6401, 6402, 6403, 6404, 6405, 6406, 6407}, 16'h00F0);

        // CLEAR interrupted by reset at pixel 100
        start(16'h2000, '0, '0);
        bad = 0;
        while (wa.size() < 100 && bad < 200) begin tick(); bad++; end
        check("clr_reach100", 32'(wa.size()), 100);
        #1 rst = 1'b1;
        #1;
        check("midrst_write", 32'(wr), 0);
        check("midrst_addr", 32'(addr), 0);
        check("midrst_data", 32'(data), 0);
        check("midrst_stall", 32'(stall), 0);
        check("midrst_drop", 32'(drop), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 0);

        // full CLEAR after reset uses colour 0x000
        start(16'h2000, '0, '0);
        drain("clear", 80000);
        check("clear_count", 32'(wa.size()), 76800);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != 0) bad++;
        check("clear_bad_entries", 32'(bad), 0);
        check("clear_stall", 32'(nstall), 76802);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
